data_bus_arbiter: RTL
=====================

Name: data_bus_arbiter

Overview:
- Shares the single data-memory / peripheral port between two requesters: M0 (core load/store path) and M1 (program loader / debug port).
- Each transaction is a single word, half or byte access.
- Round-robin arbitration, one outstanding transaction at a time.
- Alignment check before issue; watchdog abort when the memory never acknowledges.

Parameters:
- ADDR_WIDTH, 32, address width of requesters and memory port
- DATA_WIDTH, 32, data width
- TIMEOUT, 16, BUSY cycles without mem_ack before abort (2..255)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- m0_req  in  1  M0 access request; held with fields stable until m0_done
- m0_we  in  1  1 = write, 0 = read
- m0_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- m0_addr  in  ADDR_WIDTH  byte address
- m0_wdata  in  DATA_WIDTH  write data
- m0_rdata  out  DATA_WIDTH  read data, valid while m0_done=1
- m0_done  out  1  one-cycle completion pulse
- m0_err  out  1  one-cycle error pulse, coincident with m0_done
- m1_req, m1_we, m1_size, m1_addr, m1_wdata, m1_rdata, m1_done, m1_err  (same as M0, for M1)
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  registered copy of the winner's we
- mem_size  out  2  registered copy of the winner's size
- mem_addr  out  ADDR_WIDTH  registered copy of the winner's address
- mem_wdata  out  DATA_WIDTH  registered copy of the winner's write data
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle
- mem_rdata  in  DATA_WIDTH  memory read data, passed unextended
- busy  out  1  high while in state BUSY
- owner  out  1  current or last granted requester (0 = M0, 1 = M1)

Behaviour:
- Reset (async, immediate):
  - All outputs 0; state IDLE.
  - last_grant = 1, so M0 wins the first tie.
  - Watchdog counter = 0; mem_req drops immediately, even mid-transaction.
- Request masking: a requester whose done is high this cycle is masked from arbitration, so it can drop req without being regranted.
- IDLE, no unmasked req: stay in IDLE.
- IDLE, exactly one unmasked req: grant it.
- IDLE, both reqs: grant !last_grant (round-robin).
- On grant, alignment is checked:
  - Misaligned means size=01 with addr[0]=1, size=10 with addr[1:0]!=0, or size=11.
  - Misaligned: no memory access. Next cycle the winner's done=1, err=1, rdata=0. State stays IDLE. last_grant updated.
  - Aligned: latch we/size/addr/wdata into the mem_* registers, set mem_req=1, owner=winner, last_grant=winner, counter=0, state BUSY.
- BUSY:
  - mem_req and all mem_* fields stable; requester inputs ignored, including req deassertion.
  - If mem_ack is sampled: next cycle mem_req=0, the owner's done=1 and err=0; rdata = mem_rdata for reads, 0 for writes. State returns to IDLE.
  - Else the counter increments. On reaching TIMEOUT-1 without ack: abort. Next cycle mem_req=0, done=1, err=1, rdata=0, IDLE.
  - mem_ack in the abort cycle counts as success (ack wins).
- mem_ack while mem_req=0 is ignored.
- Latency:
  - req high in cycle 0 gives mem_req high in cycle 1.
  - Zero-wait ack in cycle 1 gives done in cycle 2 (minimum 2 cycles).
  - New grant is possible in the done cycle, to the other requester only.
- done/err are single-cycle pulses; rdata holds its value until the next done for that requester.
- Byte/half sign extension is not done here; downstream logic handles it.

Test Plan:
- Reset, then M0 word read at 0x100, mem_ack in cycle 1 with rdata 0xDEADBEEF -> mem_req cycles 1 only; m0_done and m0_rdata=0xDEADBEEF in cycle 2; m0_err=0.
- M0 and M1 both req in the same cycle, repeatedly -> grants alternate M0, M1, M0, M1; owner toggles; no back-to-back regrant of the same master while the other waits.
- M1 half write addr 0x203 -> no mem_req; cycle 1 m1_done=1, m1_err=1. Also M0 size=11 -> same error response.
- M0 read, mem_ack never asserted, TIMEOUT=16 -> mem_req high 16 cycles, then m0_done=m0_err=1, rdata=0, busy=0.
- mem_ack in the final watchdog cycle -> success: err=0, rdata = mem_rdata.
- rst asserted mid-BUSY (no clock edge) -> mem_req, busy, done all 0 immediately. After release, a simultaneous request goes to M0.

Source files
------------

// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter sharing one data-memory port between two single-access
// requesters, with alignment check on grant and a no-ack watchdog.

// Per-requester response register: done/err pulse plus held read data.
module dba_rsp #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fire,
   input  logic                  fail,
   input  logic [DATA_WIDTH-1:0] data,
   output logic                  done,
   output logic                  err,
   output logic [DATA_WIDTH-1:0] rdata
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done  <= 1'b0;
         err   <= 1'b0;
         rdata <= '0;
      end else begin
         done <= fire;
         err  <= fire & fail;
         if (fire) rdata <= fail ? '0 : data;
      end
   end
endmodule

module data_bus_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [1:0]            m0_size,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   output logic                  m0_done,
   output logic                  m0_err,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [1:0]            m1_size,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  m1_done,
   output logic                  m1_err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [1:0]            mem_size,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy,
   output logic                  owner
);
   localparam int NREQ = 2;

   typedef struct packed {
      logic                  we;
      logic [1:0]            size;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } req_t;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   req_t [NREQ-1:0]                 rq;
   logic [NREQ-1:0]                 req_v, done_v, err_v, avail, fire;
   logic [NREQ-1:0][DATA_WIDTH-1:0] rdata_v;

   state_t                  state, state_n;
   logic [7:0]              cnt, cnt_n;
   logic                    last_grant;
   logic                    gnt, win, load, fail;
   logic [DATA_WIDTH-1:0]   rsp_data;

   assign rq[0]  = '{we: m0_we, size: m0_size, addr: m0_addr, wdata: m0_wdata};
   assign rq[1]  = '{we: m1_we, size: m1_size, addr: m1_addr, wdata: m1_wdata};
   assign req_v  = {m1_req, m0_req};
   // A requester in its done cycle may still hold req; keep it out of the race.
   assign avail  = req_v & ~done_v;

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
      case (size)
         2'b00:   return 1'b0;
         2'b01:   return a[0];
         2'b10:   return |a;
         default: return 1'b1;
      endcase
   endfunction

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      gnt      = 1'b0;
      win      = last_grant;
      load     = 1'b0;
      fire     = '0;
      fail     = 1'b0;
      rsp_data = '0;
      case (state)
         S_IDLE: begin
            if (|avail) begin
               gnt = 1'b1;
               win = (avail == 2'b11) ? ~last_grant : avail[1];
               if (misaligned(rq[win].size, rq[win].addr[1:0])) begin
                  fire[win] = 1'b1;
                  fail      = 1'b1;
               end else begin
                  load    = 1'b1;
                  cnt_n   = '0;
                  state_n = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            // Ack takes priority over the watchdog in the final cycle.
            if (mem_ack) begin
               fire[owner] = 1'b1;
               rsp_data    = mem_we ? '0 : mem_rdata;
               state_n     = S_IDLE;
            end else if (cnt == 8'(TIMEOUT - 1)) begin
               fire[owner] = 1'b1;
               fail        = 1'b1;
               state_n     = S_IDLE;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         mem_we     <= 1'b0;
         mem_size   <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (gnt) last_grant <= win;
         if (load) begin
            owner     <= win;
            mem_we    <= rq[win].we;
            mem_size  <= rq[win].size;
            mem_addr  <= rq[win].addr;
            mem_wdata <= rq[win].wdata;
         end
      end
   end

   assign mem_req = (state == S_BUSY);
   assign busy    = (state == S_BUSY);

   for (genvar i = 0; i < NREQ; i++) begin : g_rsp
      dba_rsp #(.DATA_WIDTH(DATA_WIDTH)) u_rsp (
         .clk   (clk),
         .rst   (rst),
         .fire  (fire[i]),
         .fail  (fail),
         .data  (rsp_data),
         .done  (done_v[i]),
         .err   (err_v[i]),
         .rdata (rdata_v[i])
      );
   end

   assign m0_done  = done_v[0];
   assign m0_err   = err_v[0];
   assign m0_rdata = rdata_v[0];
   assign m1_done  = done_v[1];
   assign m1_err   = err_v[1];
   assign m1_rdata = rdata_v[1];
endmodule
